// File: rtl/sr_bank_pkg.sv
// Shared encodings and helpers for the SR latch bank.
// Conflict policy codes and counter sizing live here.
package sr_bank_pkg;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_SET  = 2'd1;
  localparam logic [1:0] MODE_RST  = 2'd2;
  localparam logic [1:0] MODE_TOG  = 2'd3;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic next_q(
    input logic       cur,
    input logic       set,
    input logic       clr,
    input logic [1:0] mode
  );
    logic n;
    n = cur;
    unique case (1'b1)
      set && !clr: n = 1'b1;
      !set && clr: n = 1'b0;
      set && clr: begin
        unique case (mode)
          MODE_HOLD: n = cur;
          MODE_SET:  n = 1'b1;
          MODE_RST:  n = 1'b0;
          MODE_TOG:  n = ~cur;
          default:   n = cur;
        endcase
      end
      default: n = cur;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Multi-stage input synchroniser with async reset.
// STAGES=0 degenerates to a straight wire.
module sr_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_flops
    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++)
          pipe[i] <= '0;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < STAGES; i++)
          pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[STAGES-1];
  end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of independent clocked SR channels with synchronised
// inputs, edge pulses and sticky conflict tracking.
module sr_latch_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_Q       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0] MODE = 2'(CONFLICT_MODE);

  logic [WIDTH-1:0] ss;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] both;
  logic             any_both;

  sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_s (
    .clk (clk),
    .rst (rst),
    .d   (s),
    .q   (ss)
  );

  sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_r (
    .clk (clk),
    .rst (rst),
    .d   (r),
    .q   (rs)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    assign q_nxt[i] = next_q(q[i], ss[i], rs[i], MODE);
    assign both[i]  = ss[i] & rs[i];
  end

  assign any_both = |both;
  // Derived from q so the pair can never agree, even in reset.
  assign qb = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RESET_Q;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= q_nxt;
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end
  end

  // A conflict arriving with clr_err restarts the tally at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict     <= '0;
      conflict_cnt <= '0;
    end else if (clr_err) begin
      conflict     <= both;
      conflict_cnt <= any_both ? CNT_W'(1) : '0;
    end else begin
      conflict <= conflict | both;
      if (any_both && conflict_cnt != CNT_MAX)
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: four conflict modes at
// two sync stages plus a zero-stage instance with RESET_Q=A5.
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s;
  logic [7:0] r;
  logic       clr_err;

  logic [7:0] q    [5];
  logic [7:0] qb   [5];
  logic [7:0] rise [5];
  logic [7:0] fall [5];
  logic [7:0] cf   [5];
  logic [7:0] cnt  [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_bank #(.CONFLICT_MODE(0)) d0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_err(clr_err),
    .q(q[0]), .qb(qb[0]), .rise(rise[0]), .fall(fall[0]),
    .conflict(cf[0]), .conflict_cnt(cnt[0]));

  sr_latch_bank #(.CONFLICT_MODE(1)) d1 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_err(clr_err),
    .q(q[1]), .qb(qb[1]), .rise(rise[1]), .fall(fall[1]),
    .conflict(cf[1]), .conflict_cnt(cnt[1]));

  sr_latch_bank #(.CONFLICT_MODE(2)) d2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_err(clr_err),
    .q(q[2]), .qb(qb[2]), .rise(rise[2]), .fall(fall[2]),
    .conflict(cf[2]), .conflict_cnt(cnt[2]));

  sr_latch_bank #(.CONFLICT_MODE(3)) d3 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_err(clr_err),
    .q(q[3]), .qb(qb[3]), .rise(rise[3]), .fall(fall[3]),
    .conflict(cf[3]), .conflict_cnt(cnt[3]));

  sr_latch_bank #(
    .SYNC_STAGES(0), .CONFLICT_MODE(0), .RESET_Q(8'hA5)
  ) d4 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_err(clr_err),
    .q(q[4]), .qb(qb[4]), .rise(rise[4]), .fall(fall[4]),
    .conflict(cf[4]), .conflict_cnt(cnt[4]));

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    s = '0;
    r = '0;
    clr_err = 1'b0;
    #3;
    chk("rst_q",    q[0],  8'h00);
    chk("rst_qb",   qb[0], 8'hFF);
    chk("rst_cf",   cf[0], 8'h00);
    chk("rst_cnt",  cnt[0], 8'h00);
    chk("rst_q4",   q[4],  8'hA5);
    chk("rst_qb4",  qb[4], 8'h5A);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rel_rise", rise[0] | rise[4], 8'h00);
    chk("rel_fall", fall[0] | fall[4], 8'h00);

    // single-cycle set pulse on channel 3
    s = 8'h08;
    step();
    s = '0;
    chk("lat_e0", q[0], 8'h00);
    step();
    chk("lat_e1", q[0], 8'h00);
    step();
    chk("lat_q",    q[0],    8'h08);
    chk("lat_qb",   qb[0],   8'hF7);
    chk("lat_rise", rise[0], 8'h08);
    step();
    chk("lat_rise2", rise[0], 8'h00);
    chk("lat_hold",  q[0],    8'h08);

    // three conflict cycles on channel 0
    do_reset();
    s = 8'h01;
    r = 8'h01;
    step();
    step();
    step();
    s = '0;
    r = '0;
    chk("tog_e1", q[3], 8'h01);
    step();
    chk("tog_e2", q[3], 8'h00);
    chk("tog_f2", fall[3], 8'h01);
    step();
    chk("tog_e3",  q[3],   8'h01);
    chk("tog_r3",  rise[3], 8'h01);
    chk("tog_cf",  cf[3],  8'h01);
    chk("tog_cnt", cnt[3], 8'd3);
    chk("hold_q",  q[0],   8'h00);
    chk("set_q",   q[1],   8'h01);
    chk("rst_mq",  q[2],   8'h00);
    chk("cnt0",    cnt[0], 8'd3);
    step();
    chk("tog_end", q[3], 8'h01);

    // saturation then clear with conflict still present
    s = 8'hFF;
    r = 8'hFF;
    for (int i = 0; i < 300; i++)
      step();
    chk("sat_cnt", cnt[0], 8'd255);
    chk("sat_cf",  cf[0],  8'hFF);
    chk("sat_q1",  q[1],   8'hFF);
    chk("sat_q2",  q[2],   8'h00);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_cnt", cnt[0], 8'd1);
    chk("clr_cf",  cf[0],  8'hFF);
    chk("clr_q1",  q[1],   8'hFF);
    step();
    chk("clr_cnt2", cnt[0], 8'd2);
    s = '0;
    r = '0;
    step();
    step();
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_idle_cnt", cnt[0], 8'd0);
    chk("clr_idle_cf",  cf[0],  8'h00);
    chk("clr_keep_q",   q[1],   8'hFF);

    // reset with s[5] in flight
    s = 8'h20;
    step();
    s = '0;
    rst = 1'b1;
    #1;
    chk("mid_q1",  q[1],  8'h00);
    chk("mid_qb1", qb[1], 8'hFF);
    chk("mid_q4",  q[4],  8'hA5);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_q",  q[0] | q[1] | q[3], 8'h00);
      chk("post_rf", rise[0] | fall[0] | rise[1], 8'h00);
    end

    // zero-stage instance, immediate reset request
    chk("z_q",  q[4],  8'hA5);
    chk("z_qb", qb[4], 8'h5A);
    r = 8'hFF;
    step();
    r = '0;
    chk("z_q0",   q[4],    8'h00);
    chk("z_fall", fall[4], 8'hA5);
    chk("z_rise", rise[4], 8'h00);
    step();
    chk("z_fall2", fall[4], 8'h00);
    chk("z_qhold", q[4],    8'h00);
    chk("z_qb2",   qb[4],   8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank.md
SR_LATCH_BANK -- requirements
Module: sr_latch_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent SR channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth (0..3); 0 means s/r are sampled directly.
REQ-003 Parameter CONFLICT_MODE, default 0: action when s=r=1; 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-004 Parameter RESET_Q, default {WIDTH{1'b0}}: per-channel q value applied at reset.
REQ-005 One clock and one reset: clock is clk and reset is rst; rst is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 s  input  WIDTH  per-channel set request, level-sensitive.
REQ-009 r  input  WIDTH  per-channel reset request, level-sensitive.
REQ-010 clr_err  input  1  clears the conflict flags and the conflict counter.
REQ-011 q  output  WIDTH  registered channel state.
REQ-012 qb  output  WIDTH  registered complement of q.
REQ-013 rise  output  WIDTH  one-cycle pulse when q goes 0->1.
REQ-014 fall  output  WIDTH  one-cycle pulse when q goes 1->0.
REQ-015 conflict  output  WIDTH  sticky per-channel flag: s=r=1 was seen.
REQ-016 conflict_cnt  output  8  saturating count of conflict cycles.

Function
REQ-017 s and r SHALL each pass through SYNC_STAGES flops; ss/rs denote the synchroniser outputs.
REQ-018 Latency SHALL be fixed: an s/r level present before edge k updates q at edge k+SYNC_STAGES.
REQ-019 Per channel, on each edge: ss=1,rs=0 -> q=1; ss=0,rs=1 -> q=0; ss=rs=0 -> hold.
REQ-020 When ss=rs=1, q SHALL follow CONFLICT_MODE: hold, 1, 0, or ~q.
REQ-021 qb SHALL equal ~q in every cycle, including during and after reset; q=qb SHALL never occur.
REQ-022 rise[i]/fall[i] SHALL be registered with q and high only in the first cycle q[i] shows its new value.
REQ-023 conflict[i] SHALL set on any edge where ss[i]=rs[i]=1 and hold until clr_err or rst.
REQ-024 conflict_cnt SHALL increment by 1 per edge where any channel has ss=rs=1, saturating at 255.
REQ-025 clr_err together with a new conflict: the new conflict wins; flags are set for the conflicting channels only, and conflict_cnt=1.
REQ-026 clr_err SHALL NOT affect q, qb, rise, fall or the synchronisers.
REQ-027 Channels SHALL be fully independent; a conflict on one channel SHALL NOT affect any other channel's q.

Reset
REQ-028 On rst=1, regardless of clk: q=RESET_Q, qb=~RESET_Q, rise=fall=0, conflict=0, conflict_cnt=0, all synchroniser flops 0.
REQ-029 Reset mid-operation SHALL flush the synchronisers; no pre-reset s/r value SHALL affect q after release.
REQ-030 After rst deasserts, the first update SHALL use inputs sampled at or after the first post-release edge.
REQ-031 rise/fall SHALL NOT pulse because of the reset value itself or the reset release.

Structure
REQ-032 A shared package sr_bank_pkg SHALL hold the CONFLICT_MODE encodings (MODE_HOLD, MODE_SET, MODE_RST, MODE_TOG) and CNT_W=8.
REQ-033 One sub-module sr_sync (WIDTH-bit, STAGES-deep synchroniser with async reset) SHALL be instantiated twice, for s and r.
REQ-034 Per-channel next-state logic SHALL be a generate loop over WIDTH in the top level.

Verification
REQ-035 WIDTH=8, SYNC_STAGES=2, mode 0: pulse s[3] for 1 cycle -> q[3]=1 two edges later, rise[3] pulses once, qb[3]=0, other channels unchanged.
REQ-036 s[0]=r[0]=1 held 3 cycles, mode 3 -> q[0] toggles each edge; conflict[0]=1; conflict_cnt=3.
REQ-037 Repeat REQ-036 in modes 0/1/2 from q[0]=0 -> q[0] stays 0 / becomes 1 / stays 0.
REQ-038 Hold s=r=8'hFF for 300 cycles -> conflict_cnt saturates at 255; clr_err with conflict still present -> conflict_cnt=1, conflict=8'hFF.
REQ-039 Assert s[5], then assert rst mid-pipeline for 1 cycle -> q=RESET_Q immediately; q[5] never rises after release; no rise/fall pulse.
REQ-040 SYNC_STAGES=0, RESET_Q=8'hA5 -> after reset q=8'hA5, qb=8'h5A; r=8'hFF for 1 cycle -> q=0 next edge, fall=8'hA5 for one cycle.
